// File: rtl/lcd_list_pkg.sv
// Shared types and constants for the LCD list-page sequencer: FSM states,
// HD44780-style command bytes, DDRAM line bases and the page header text.
package lcd_list_pkg;

  typedef enum logic [3:0] {
    IDLE, CLR, HDR_POS, HDR_CH, ROW_POS, NM_RD, NM_CAP, NM_WR,
    AIS_POS, P_WR, AIS_RD, AIS_CAP, DIG_WR
  } state_t;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] HDR_COL       = 8'h04;
  localparam int         HDR_LEN       = 12;

  localparam logic [7:0] ROW_BASE [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

  // "Lista previa"
  localparam logic [7:0] HDR_TEXT [HDR_LEN] = '{
    8'h4C, 8'h69, 8'h73, 8'h74, 8'h61, 8'h20,
    8'h70, 8'h72, 8'h65, 8'h76, 8'h69, 8'h61
  };

  localparam logic [7:0] ASCII_P = 8'h50;
  localparam logic [7:0] ASCII_0 = 8'h30;

  function automatic logic [7:0] ddram_cmd(input logic [1:0] line, input int col);
    return CMD_SET_DDRAM | (ROW_BASE[line] + 8'(col));
  endfunction

endpackage

// File: rtl/lcd_list_view_if.sv
// Memory-read and LCD-transfer signals between the list sequencer (master)
// and the product memory / LCD command-data driver (slave).
interface lcd_list_view_if #(
  parameter int ADDR_W = 8
);
  // mem_rd is a one-cycle strobe; mem_rdata is valid exactly one cycle later.
  // An LCD transfer completes on a cycle with lcd_valid & lcd_ready; while
  // lcd_valid is high and lcd_ready low, lcd_valid/lcd_rs/lcd_data hold stable.
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              lcd_valid;
  logic              lcd_rs;
  logic [7:0]        lcd_data;
  logic              lcd_ready;

  modport master (
    output mem_rd, mem_addr, lcd_valid, lcd_rs, lcd_data,
    input  mem_rdata, lcd_ready
  );

  modport slave (
    input  mem_rd, mem_addr, lcd_valid, lcd_rs, lcd_data,
    output mem_rdata, lcd_ready
  );
endinterface

// File: rtl/lcd_bin2dec.sv
// Combinational 8-bit binary to three BCD digits, plus the number of digits
// left after leading-zero suppression (1..3).
module lcd_bin2dec (
  input  logic [7:0] bin,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [1:0] digits
);
  always_comb begin
    hundreds = 4'(bin / 8'd100);
    tens     = 4'((bin % 8'd100) / 8'd10);
    units    = 4'(bin % 8'd10);
    if (hundreds != 4'd0)  digits = 2'd3;
    else if (tens != 4'd0) digits = 2'd2;
    else                   digits = 2'd1;
  end
endmodule

// File: rtl/lcd_list_view.sv
// List-page sequencer: on refresh/scroll it clears the LCD, writes the header
// and then one product row (name, 'P', decimal aisle) per visible line.
module lcd_list_view
  import lcd_list_pkg::*;
#(
  parameter int ROWS       = 3,
  parameter int NAME_LEN   = 6,
  parameter int REC_STRIDE = 10,
  parameter int BASE_ADDR  = 14,
  parameter int NUM_RECS   = 4,
  parameter int AISLE_OFS  = 7,
  parameter int NAME_COL   = 3,
  parameter int AISLE_COL  = 14,
  parameter int ADDR_W     = 8,
  parameter int WRAP       = 0,
  localparam int IDX_W     = (NUM_RECS > 1) ? $clog2(NUM_RECS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             refresh,
  input  logic             scroll_down,
  input  logic             scroll_up,
  lcd_list_view_if.master  bus,
  output logic             busy,
  output logic [IDX_W-1:0] top_idx,
  output logic [7:0]       top_aisle,
  output state_t           dbg_state
);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_RECS - ROWS);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [1:0]  row;
  logic [7:0]  cap;
  logic [3:0]  dig_h, dig_t, dig_u, cur_dig;
  logic [1:0]  dig_sel;
  logic        pending;
  logic [3:0]  b2d_h, b2d_t, b2d_u;
  logic [1:0]  b2d_n;
  logic [3:0]  hdr_idx;
  logic        valid, rs, rd, accept;
  logic [7:0]  data;
  logic        start, go_down, go_up, can_down, can_up, launch;

  lcd_bin2dec u_b2d (
    .bin      (bus.mem_rdata),
    .hundreds (b2d_h),
    .tens     (b2d_t),
    .units    (b2d_u),
    .digits   (b2d_n)
  );

  assign start    = refresh | pending;
  assign go_down  = scroll_down & ~scroll_up;
  assign go_up    = scroll_up & ~scroll_down;
  assign can_down = (top_idx < MAX_IDX) || (WRAP != 0);
  assign can_up   = (top_idx != '0) || (WRAP != 0);
  assign launch   = start | (go_down & can_down) | (go_up & can_up);
  assign accept   = valid & bus.lcd_ready;
  assign hdr_idx  = (cnt < 8'(HDR_LEN)) ? cnt[3:0] : 4'd0;
  assign cur_dig  = (dig_sel == 2'd0) ? dig_h : (dig_sel == 2'd1) ? dig_t : dig_u;

  always_comb begin
    state_nxt = state;
    valid     = 1'b0;
    rs        = 1'b0;
    data      = 8'h00;
    rd        = 1'b0;
    case (state)
      IDLE:    if (launch) state_nxt = CLR;
      CLR: begin
        valid = 1'b1;
        data  = CMD_CLEAR;
        if (bus.lcd_ready) state_nxt = HDR_POS;
      end
      HDR_POS: begin
        valid = 1'b1;
        data  = CMD_SET_DDRAM | HDR_COL;
        if (bus.lcd_ready) state_nxt = HDR_CH;
      end
      HDR_CH: begin
        valid = 1'b1;
        rs    = 1'b1;
        data  = HDR_TEXT[hdr_idx];
        if (bus.lcd_ready && cnt == 8'(HDR_LEN - 1)) state_nxt = ROW_POS;
      end
      ROW_POS: begin
        valid = 1'b1;
        data  = ddram_cmd(row + 2'd1, NAME_COL);
        if (bus.lcd_ready) state_nxt = NM_RD;
      end
      NM_RD: begin
        rd        = 1'b1;
        state_nxt = NM_CAP;
      end
      NM_CAP:  state_nxt = NM_WR;
      NM_WR: begin
        valid = 1'b1;
        rs    = 1'b1;
        data  = cap;
        if (bus.lcd_ready)
          state_nxt = (cnt == 8'(NAME_LEN - 1)) ? AIS_POS : NM_RD;
      end
      AIS_POS: begin
        valid = 1'b1;
        data  = ddram_cmd(row + 2'd1, AISLE_COL);
        if (bus.lcd_ready) state_nxt = P_WR;
      end
      P_WR: begin
        valid = 1'b1;
        rs    = 1'b1;
        data  = ASCII_P;
        if (bus.lcd_ready) state_nxt = AIS_RD;
      end
      AIS_RD: begin
        rd        = 1'b1;
        state_nxt = AIS_CAP;
      end
      AIS_CAP: state_nxt = DIG_WR;
      DIG_WR: begin
        valid = 1'b1;
        rs    = 1'b1;
        data  = ASCII_0 + {4'd0, cur_dig};
        if (bus.lcd_ready && dig_sel == 2'd2)
          state_nxt = (row == 2'(ROWS - 1)) ? IDLE : ROW_POS;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      row       <= '0;
      cap       <= '0;
      dig_h     <= '0;
      dig_t     <= '0;
      dig_u     <= '0;
      dig_sel   <= '0;
      pending   <= 1'b0;
      top_idx   <= '0;
      top_aisle <= '0;
    end else begin
      state <= state_nxt;
      if (refresh && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          row <= '0;
          if (start)
            pending <= 1'b0;
          else if (go_down && can_down)
            top_idx <= (top_idx < MAX_IDX) ? top_idx + 1'b1 : '0;
          else if (go_up && can_up)
            top_idx <= (top_idx != '0) ? top_idx - 1'b1 : MAX_IDX;
        end
        HDR_CH, NM_WR: if (accept) cnt <= cnt + 8'd1;
        ROW_POS:       if (accept) cnt <= '0;
        NM_CAP:        cap <= bus.mem_rdata;
        AIS_CAP: begin
          dig_h   <= b2d_h;
          dig_t   <= b2d_t;
          dig_u   <= b2d_u;
          dig_sel <= 2'd3 - b2d_n;
          if (row == 2'd0) top_aisle <= bus.mem_rdata;
        end
        DIG_WR: if (accept) begin
          if (dig_sel == 2'd2) row <= row + 2'd1;
          else                 dig_sel <= dig_sel + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // The aisle read uses a fixed offset; name reads walk cnt across the record.
  assign bus.mem_rd    = rd;
  assign bus.mem_addr  = rd ? ADDR_W'(BASE_ADDR + (int'(top_idx) + int'(row)) * REC_STRIDE
                              + ((state == AIS_RD) ? AISLE_OFS : int'(cnt))) : '0;
  assign bus.lcd_valid = valid;
  assign bus.lcd_rs    = rs;
  assign bus.lcd_data  = data;
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_lcd_list_view.sv
// Directed bench for lcd_list_view: a clamp-scrolling instance with LCD and
// memory models, plus a wrap-scrolling instance for the wrap cases.
module tb_lcd_list_view;
  import lcd_list_pkg::*;

  localparam logic [7:0] POS_CMD [3] = '{8'hC3, 8'h97, 8'hD7};
  localparam logic [7:0] AIS_CMD [3] = '{8'hCE, 8'hA2, 8'hE2};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic refresh_a = 1'b0, down_a = 1'b0, up_a = 1'b0;
  logic refresh_b = 1'b0, down_b = 1'b0, up_b = 1'b0;
  logic busy_a, busy_b;
  logic [1:0] top_a, top_b;
  logic [7:0] aisle_a, aisle_b;
  state_t st_a, st_b;

  logic [7:0] mem [256];
  logic [8:0] exp_q[$], got_q[$];
  logic [7:0] exp_rd[$], rd_q[$];
  int n_chk = 0;
  int n_err = 0;

  lcd_list_view_if #(.ADDR_W(8)) bus_a ();
  lcd_list_view_if #(.ADDR_W(8)) bus_b ();

  lcd_list_view #(.WRAP(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .refresh(refresh_a), .scroll_down(down_a),
    .scroll_up(up_a), .bus(bus_a.master), .busy(busy_a), .top_idx(top_a),
    .top_aisle(aisle_a), .dbg_state(st_a)
  );

  lcd_list_view #(.WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .refresh(refresh_b), .scroll_down(down_b),
    .scroll_up(up_b), .bus(bus_b.master), .busy(busy_b), .top_idx(top_b),
    .top_aisle(aisle_b), .dbg_state(st_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory + LCD models
  always @(posedge clk) begin
    if (bus_a.mem_rd) begin
      bus_a.mem_rdata <= mem[bus_a.mem_addr];
      rd_q.push_back(bus_a.mem_addr);
    end
    if (bus_a.lcd_valid && bus_a.lcd_ready) got_q.push_back({bus_a.lcd_rs, bus_a.lcd_data});
  end

  always @(posedge clk) begin
    if (bus_b.mem_rd) bus_b.mem_rdata <= mem[bus_b.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_rec(input int idx, input string name, input logic [7:0] aisle);
    for (int j = 0; j < 6; j++) mem[14 + idx * 10 + j] = name[j];
    mem[14 + idx * 10 + 7] = aisle;
  endtask

  // driver tasks
  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: refresh_a = 1'b1;
      1: down_a = 1'b1;
      2: up_a = 1'b1;
      3: down_b = 1'b1;
      default: up_b = 1'b1;
    endcase
    @(negedge clk);
    refresh_a = 1'b0; down_a = 1'b0; up_a = 1'b0;
    down_b = 1'b0; up_b = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input bit inst_b);
    int n = 0;
    while ((inst_b ? busy_b : busy_a) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, inst_b ? busy_b : busy_a, 0);
  endtask

  // scoreboard: expected transfers and reads for one redraw starting at top
  task automatic build_exp(input int top);
    string hdr = "Lista previa";
    string s;
    int base;
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h084);
    for (int i = 0; i < 12; i++) exp_q.push_back({1'b1, hdr[i]});
    for (int k = 0; k < 3; k++) begin
      base = 14 + (top + k) * 10;
      exp_q.push_back({1'b0, POS_CMD[k]});
      for (int j = 0; j < 6; j++) begin
        exp_q.push_back({1'b1, mem[base + j]});
        exp_rd.push_back(8'(base + j));
      end
      exp_q.push_back({1'b0, AIS_CMD[k]});
      exp_q.push_back({1'b1, 8'h50});
      exp_rd.push_back(8'(base + 7));
      s = $sformatf("%0d", mem[base + 7]);
      for (int i = 0; i < s.len(); i++) exp_q.push_back({1'b1, s[i]});
    end
  endtask

  task automatic cmp_seq(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_xfer%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_rdlen"}, rd_q.size(), exp_rd.size());
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
      chk($sformatf("%s_rd%0d", tag, i), rd_q[i], exp_rd[i]);
  endtask

  task automatic clear_q();
    got_q.delete(); exp_q.delete(); rd_q.delete(); exp_rd.delete();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    set_rec(0, "MANZAN", 8'd7);
    set_rec(1, "PERAS ", 8'd12);
    set_rec(2, "UVAS  ", 8'd255);
    set_rec(3, "LIMON ", 8'd99);
    bus_a.lcd_ready = 1'b1;
    bus_b.lcd_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", bus_a.lcd_valid, 0);
    chk("rst_rs", bus_a.lcd_rs, 0);
    chk("rst_data", bus_a.lcd_data, 0);
    chk("rst_mem_rd", bus_a.mem_rd, 0);
    chk("rst_mem_addr", bus_a.mem_addr, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_top", top_a, 0);
    chk("rst_aisle", aisle_a, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // first redraw: aisle 7 on row 1
    clear_q();
    build_exp(0);
    pulse(0);
    chk("draw1_busy", busy_a, 1);
    wait_idle("draw1", 1'b0);
    cmp_seq("draw1");
    if (got_q.size() > 23) begin
      chk("draw1_pos", got_q[14], 9'h0C3);
      chk("draw1_ais", got_q[21], 9'h0CE);
      chk("draw1_dig", got_q[23], 9'h137);
    end
    chk("draw1_addr0", rd_q.size() > 0 ? rd_q[0] : 8'hFF, 8'd14);
    chk("draw1_top_aisle", aisle_a, 8'd7);

    // multi-digit / zero aisles
    set_rec(0, "MANZAN", 8'd105);
    set_rec(1, "PERAS ", 8'd40);
    set_rec(2, "UVAS  ", 8'd0);
    clear_q();
    build_exp(0);
    pulse(0);
    wait_idle("draw2", 1'b0);
    cmp_seq("draw2");
    if (got_q.size() > 25) begin
      chk("draw2_d0", got_q[23], 9'h131);
      chk("draw2_d1", got_q[24], 9'h130);
      chk("draw2_d2", got_q[25], 9'h135);
    end
    chk("draw2_top_aisle", aisle_a, 8'd105);

    // clamp scrolling
    clear_q();
    build_exp(1);
    pulse(1);
    chk("down1_top", top_a, 2'd1);
    wait_idle("down1", 1'b0);
    cmp_seq("down1");
    chk("down1_addr0", rd_q.size() > 0 ? rd_q[0] : 8'hFF, 8'd24);
    chk("down1_top_aisle", aisle_a, 8'd40);

    clear_q();
    pulse(1);
    chk("down2_busy", busy_a, 0);
    repeat (10) @(negedge clk);
    chk("down2_top", top_a, 2'd1);
    chk("down2_traffic", got_q.size(), 0);

    clear_q();
    build_exp(0);
    pulse(2);
    chk("up1_top", top_a, 2'd0);
    wait_idle("up1", 1'b0);
    cmp_seq("up1");

    // wrap scrolling on the second instance
    pulse(3);
    wait_idle("wdown1", 1'b1);
    chk("wdown1_top", top_b, 2'd1);
    pulse(3);
    chk("wdown2_busy", busy_b, 1);
    chk("wdown2_top", top_b, 2'd0);
    wait_idle("wdown2", 1'b1);
    pulse(4);
    chk("wup_busy", busy_b, 1);
    chk("wup_top", top_b, 2'd1);
    wait_idle("wup", 1'b1);

    // back-pressure on third header char, plus refresh while busy
    clear_q();
    build_exp(0);
    build_exp(0);
    pulse(0);
    n = 0;
    while (!(bus_a.lcd_valid && bus_a.lcd_rs && bus_a.lcd_data == 8'h73) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_found", bus_a.lcd_data, 8'h73);
    bus_a.lcd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      refresh_a = (i == 1);
      chk($sformatf("stall_valid%0d", i), bus_a.lcd_valid, 1);
      chk($sformatf("stall_data%0d", i), bus_a.lcd_data, 8'h73);
    end
    refresh_a = 1'b0;
    bus_a.lcd_ready = 1'b1;
    wait_idle("stall1", 1'b0);
    @(negedge clk);
    chk("pending_restart", busy_a, 1);
    wait_idle("stall2", 1'b0);
    repeat (20) @(negedge clk);
    chk("pending_once", busy_a, 0);
    cmp_seq("stall");

    // reset during row 2
    clear_q();
    pulse(1);
    n = 0;
    while (!(bus_a.lcd_valid && !bus_a.lcd_rs && bus_a.lcd_data == 8'h97) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_found", bus_a.lcd_data, 8'h97);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", bus_a.lcd_valid, 0);
    chk("rst_mid_busy", busy_a, 0);
    chk("rst_mid_top", top_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    repeat (30) @(negedge clk);
    chk("rst_quiet", got_q.size(), 0);
    chk("rst_quiet_busy", busy_a, 0);

    clear_q();
    build_exp(0);
    pulse(0);
    wait_idle("post_rst", 1'b0);
    cmp_seq("post_rst");

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
